// File: rtl/wb_wait_bridge_pkg.sv
// Shared types and widths for the wait-state bridge.
package wb_tb_pkg;

   localparam int WB_ADR_W = 30;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;
   localparam logic [WB_DAT_W-1:0] WB_FAULT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_ACK
   } wb_wait_state_t;

endpackage

// File: rtl/wb_wait_bridge_if.sv
// Bus bundle for the bridge: core request side (m_*) and memory side (s_*).
// The slave modport is the bridge's view; master is the surrounding
// core/memory environment.
interface wb_wait_bridge_if;
   import wb_tb_pkg::*;

   logic                m_cyc_i;
   logic                m_stb_i;
   logic                m_we_i;
   logic [WB_SEL_W-1:0] m_sel_i;
   logic [WB_ADR_W-1:0] m_adr_i;
   logic [WB_DAT_W-1:0] m_dat_i;
   logic                m_ack_o;
   logic [WB_DAT_W-1:0] m_dat_o;
   logic                s_cyc_o;
   logic                s_stb_o;
   logic                s_we_o;
   logic [WB_SEL_W-1:0] s_sel_o;
   logic [WB_ADR_W-1:0] s_adr_o;
   logic [WB_DAT_W-1:0] s_dat_o;
   logic                s_ack_i;
   logic [WB_DAT_W-1:0] s_dat_i;
   logic                fault_o;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      output m_ack_o, m_dat_o,
      output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      input  s_ack_i, s_dat_i,
      output fault_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      input  m_ack_o, m_dat_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      output s_ack_i, s_dat_i,
      input  fault_o
   );

endinterface

// File: rtl/wb_wait_bridge_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps once per advance pulse.
module wb_lfsr16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   // Shift register, reloaded with the seed on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= seed;
      end else if (advance) begin
         value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
      end
   end

endmodule

// File: rtl/wb_wait_bridge.sv
// Wait-state bridge between the core bus master and the memory decode.
// Build option: define WB_RANDOM_WAIT_EN to draw the per-request wait count
// from an LFSR instead of the fixed WAIT_CYCLES value.
//
// state     | meaning
// ST_IDLE   | waiting for m_cyc_i & m_stb_i, request fields latched on accept
// ST_WAIT   | counting down inserted wait states, m_cyc_i drop aborts
// ST_ACCESS | memory strobe driven, ends on s_ack_i or timeout
// ST_ACK    | one-cycle m_ack_o to the core (unless the core dropped cyc)
module wb_wait_bridge
   import wb_tb_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned TIMEOUT     = 16,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input logic             clk,
   input logic             rst,
   wb_wait_bridge_if.slave bus
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   wb_wait_state_t      state_q, state_d;
   logic [3:0]          wait_cnt_q;
   logic [3:0]          wait_init;
   logic [TO_W-1:0]     to_cnt_q;
   logic                req;
   logic                timed_out;
   logic                drop_q;
   logic                we_q;
   logic                ack_q;
   logic                fault_q;
   logic [WB_ADR_W-1:0] adr_q;
   logic [WB_DAT_W-1:0] wdat_q;
   logic [WB_DAT_W-1:0] rdat_q;
   logic [WB_SEL_W-1:0] sel_q;

   assign req       = bus.m_cyc_i & bus.m_stb_i;
   assign timed_out = (to_cnt_q == TO_W'(TIMEOUT));

`ifdef WB_RANDOM_WAIT_EN
   logic [15:0] lfsr_value;

   wb_lfsr16 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .advance (state_q == ST_IDLE && req),
      .seed    (LFSR_SEED),
      .value   (lfsr_value)
   );

   assign wait_init = lfsr_value[3:0];
`else
   localparam logic [15:0] unused_lfsr_seed = LFSR_SEED;

   assign wait_init = 4'(WAIT_CYCLES);
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (req) state_d = (wait_init == 4'd0) ? ST_ACCESS : ST_WAIT;
         ST_WAIT:   if (!bus.m_cyc_i)            state_d = ST_IDLE;
                    else if (wait_cnt_q == 4'd1) state_d = ST_ACCESS;
         ST_ACCESS: if (bus.s_ack_i || timed_out) state_d = ST_ACK;
         ST_ACK:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Request latch, counters, read data capture, ack pulse and sticky fault.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adr_q      <= '0;
         wdat_q     <= '0;
         sel_q      <= '0;
         we_q       <= 1'b0;
         wait_cnt_q <= '0;
         to_cnt_q   <= '0;
         drop_q     <= 1'b0;
         ack_q      <= 1'b0;
         rdat_q     <= '0;
         fault_q    <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  adr_q      <= bus.m_adr_i;
                  wdat_q     <= bus.m_dat_i;
                  sel_q      <= bus.m_sel_i;
                  we_q       <= bus.m_we_i;
                  wait_cnt_q <= wait_init;
                  to_cnt_q   <= '0;
                  drop_q     <= 1'b0;
               end
            end
            ST_WAIT: wait_cnt_q <= wait_cnt_q - 4'd1;
            ST_ACCESS: begin
               // A core that walked away mid-access still gets the access
               // finished, but never sees the ack for it.
               if (!bus.m_cyc_i) drop_q <= 1'b1;
               if (bus.s_ack_i) begin
                  if (!we_q) rdat_q <= bus.s_dat_i;
                  ack_q <= bus.m_cyc_i & ~drop_q;
               end else if (timed_out) begin
                  fault_q <= 1'b1;
                  rdat_q  <= WB_FAULT_DATA;
                  ack_q   <= bus.m_cyc_i & ~drop_q;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.m_ack_o = ack_q;
   assign bus.m_dat_o = rdat_q;
   assign bus.s_cyc_o = (state_q == ST_ACCESS);
   assign bus.s_stb_o = (state_q == ST_ACCESS);
   assign bus.s_we_o  = (state_q == ST_ACCESS) & we_q;
   assign bus.s_sel_o = sel_q;
   assign bus.s_adr_o = adr_q;
   assign bus.s_dat_o = wdat_q;
   assign bus.fault_o = fault_q;

endmodule

// File: tb/tb_wb_wait_bridge.sv
// Directed bench for wb_wait_bridge: three bridges (W=0, W=2, W=3) share one
// memory model; only the selected bridge sees the request strobes.
module tb_wb_wait_bridge;
   import wb_tb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        preload = 1'b1;
   logic        m_cyc = 1'b0;
   logic        m_stb = 1'b0;
   logic        m_we = 1'b0;
   logic [3:0]  m_sel = '0;
   logic [29:0] m_adr = '0;
   logic [31:0] m_dat = '0;
   int          act = 2;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] mem [0:511];

   wb_wait_bridge_if bus_w0 ();
   wb_wait_bridge_if bus_w2 ();
   wb_wait_bridge_if bus_w3 ();

   wb_wait_bridge #(.WAIT_CYCLES(0), .TIMEOUT(16), .LFSR_SEED(16'hACE1)) dut_w0 (.clk(clk), .rst(rst), .bus(bus_w0));
   wb_wait_bridge #(.WAIT_CYCLES(2), .TIMEOUT(16), .LFSR_SEED(16'hACE1)) dut_w2 (.clk(clk), .rst(rst), .bus(bus_w2));
   wb_wait_bridge #(.WAIT_CYCLES(3), .TIMEOUT(16), .LFSR_SEED(16'hACE1)) dut_w3 (.clk(clk), .rst(rst), .bus(bus_w3));

   always #5 clk = ~clk;

   // text: 30'h0010_00xx, data: 30'h0020_00xx, 256 words each
   function automatic logic mapped(input logic [29:0] a);
      return (a[29:8] == 22'h001000) || (a[29:8] == 22'h002000);
   endfunction

   function automatic logic [8:0] widx(input logic [29:0] a);
      return {a[21], a[7:0]};
   endfunction

   function automatic logic [31:0] init_word(input int i);
      if (i == 0)       return 32'h1234_5678;
      if (i == 1)       return 32'hCAFE_F00D;
      if (i == 256 + 5) return 32'h1122_3344;
      return 32'hA500_0000 + 32'(i);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   assign bus_w0.m_cyc_i = m_cyc && (act == 0);
   assign bus_w0.m_stb_i = m_stb && (act == 0);
   assign bus_w0.m_we_i  = m_we;
   assign bus_w0.m_sel_i = m_sel;
   assign bus_w0.m_adr_i = m_adr;
   assign bus_w0.m_dat_i = m_dat;
   assign bus_w0.s_ack_i = bus_w0.s_cyc_o & bus_w0.s_stb_o & mapped(bus_w0.s_adr_o);
   assign bus_w0.s_dat_i = mem[widx(bus_w0.s_adr_o)];

   assign bus_w2.m_cyc_i = m_cyc && (act == 2);
   assign bus_w2.m_stb_i = m_stb && (act == 2);
   assign bus_w2.m_we_i  = m_we;
   assign bus_w2.m_sel_i = m_sel;
   assign bus_w2.m_adr_i = m_adr;
   assign bus_w2.m_dat_i = m_dat;
   assign bus_w2.s_ack_i = bus_w2.s_cyc_o & bus_w2.s_stb_o & mapped(bus_w2.s_adr_o);
   assign bus_w2.s_dat_i = mem[widx(bus_w2.s_adr_o)];

   assign bus_w3.m_cyc_i = m_cyc && (act == 3);
   assign bus_w3.m_stb_i = m_stb && (act == 3);
   assign bus_w3.m_we_i  = m_we;
   assign bus_w3.m_sel_i = m_sel;
   assign bus_w3.m_adr_i = m_adr;
   assign bus_w3.m_dat_i = m_dat;
   assign bus_w3.s_ack_i = bus_w3.s_cyc_o & bus_w3.s_stb_o & mapped(bus_w3.s_adr_o);
   assign bus_w3.s_dat_i = mem[widx(bus_w3.s_adr_o)];

   // Memory: preload, then byte-lane writes committed on the edge ending ACCESS.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      end else begin
         if (bus_w0.s_we_o & bus_w0.s_ack_i)
            mem[widx(bus_w0.s_adr_o)] <= merge(mem[widx(bus_w0.s_adr_o)], bus_w0.s_dat_o, bus_w0.s_sel_o);
         if (bus_w2.s_we_o & bus_w2.s_ack_i)
            mem[widx(bus_w2.s_adr_o)] <= merge(mem[widx(bus_w2.s_adr_o)], bus_w2.s_dat_o, bus_w2.s_sel_o);
         if (bus_w3.s_we_o & bus_w3.s_ack_i)
            mem[widx(bus_w3.s_adr_o)] <= merge(mem[widx(bus_w3.s_adr_o)], bus_w3.s_dat_o, bus_w3.s_sel_o);
      end
   end

   function automatic logic obs_stb(input int d);
      case (d)
         0:       return bus_w0.s_stb_o;
         3:       return bus_w3.s_stb_o;
         default: return bus_w2.s_stb_o;
      endcase
   endfunction

   function automatic logic obs_ack(input int d);
      case (d)
         0:       return bus_w0.m_ack_o;
         3:       return bus_w3.m_ack_o;
         default: return bus_w2.m_ack_o;
      endcase
   endfunction

   function automatic logic [31:0] obs_dat(input int d);
      case (d)
         0:       return bus_w0.m_dat_o;
         3:       return bus_w3.m_dat_o;
         default: return bus_w2.m_dat_o;
      endcase
   endfunction

   // Issue one request on bridge d; cycle 0 is the cycle the request is first
   // sampled. Called and returns #1 after a rising edge.
   task automatic run_req(input int d, input logic we, input logic [29:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int drop_cyc, input int max_cyc,
                          output int ack_cyc, output int ack_cnt, output int stb_first,
                          output int stb_cnt, output logic [31:0] rdata);
      act = d; m_we = we; m_adr = adr; m_sel = sel; m_dat = dat;
      m_cyc = 1'b1; m_stb = 1'b1;
      ack_cyc = -1; ack_cnt = 0; stb_first = -1; stb_cnt = 0; rdata = '0;
      for (int c = 0; c < max_cyc; c++) begin
         if (c == drop_cyc) begin m_cyc = 1'b0; m_stb = 1'b0; end
         @(negedge clk);
         if (obs_stb(d)) begin
            stb_cnt++;
            if (stb_first < 0) stb_first = c;
         end
         if (obs_ack(d)) begin
            ack_cnt++;
            if (ack_cyc < 0) begin ack_cyc = c; rdata = obs_dat(d); end
         end
         @(posedge clk); #1;
         if (ack_cyc == c) begin m_cyc = 1'b0; m_stb = 1'b0; end
      end
      m_cyc = 1'b0; m_stb = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      preload = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus_w2.m_ack_o, bus_w2.s_cyc_o, bus_w2.s_stb_o, bus_w2.s_we_o, bus_w2.fault_o} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
            {bus_w2.m_ack_o, bus_w2.s_cyc_o, bus_w2.s_stb_o, bus_w2.s_we_o, bus_w2.fault_o});
      end
      n_checks++;
      if ({bus_w2.m_dat_o, bus_w2.s_dat_o, bus_w2.s_adr_o, bus_w2.s_sel_o} !== 98'b0) begin
         n_fail++; $display("FAIL reset_fields: m_dat %h s_dat %h s_adr %h s_sel %h expected all 0",
            bus_w2.m_dat_o, bus_w2.s_dat_o, bus_w2.s_adr_o, bus_w2.s_sel_o);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

`ifdef WB_RANDOM_WAIT_EN
   task automatic test_random;
      logic [15:0] model;
      int          start, k, lat, exp_lat;
      logic [31:0] seen;
      logic        got;
      model = 16'hACE1; start = 0; k = 0; seen = '0; got = 1'b0;
      act = 2; m_we = 1'b0; m_sel = 4'hF; m_adr = 30'h0010_0000;
      m_cyc = 1'b1; m_stb = 1'b1;
      for (int c = 0; c < 2500 && k < 100; c++) begin
         @(negedge clk);
         if (bus_w2.m_ack_o) begin
            lat = c - start;
            exp_lat = 2 + int'(model[3:0]);
            n_checks++;
            if (lat != exp_lat || lat < 2 || lat > 17) begin
               n_fail++; $display("FAIL random_latency[%0d]: got %0d expected %0d", k, lat, exp_lat);
            end
            n_checks++;
            if (bus_w2.m_dat_o !== init_word(k)) begin
               n_fail++; $display("FAIL random_data[%0d]: got %h expected %h", k, bus_w2.m_dat_o, init_word(k));
            end
            if (lat >= 0 && lat < 32) seen[lat] = 1'b1;
            model = {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};
            k++; start = c + 1; got = 1'b1;
         end
         @(posedge clk); #1;
         if (got) begin
            got = 1'b0;
            m_adr = 30'h0010_0000 + 30'(k);
            if (k == 100) begin m_cyc = 1'b0; m_stb = 1'b0; end
         end
      end
      m_cyc = 1'b0; m_stb = 1'b0;
      n_checks++;
      if (k != 100) begin n_fail++; $display("FAIL random_count: got %0d acks expected 100", k); end
      n_checks++;
      if ($countones(seen) < 2) begin
         n_fail++; $display("FAIL random_distinct: got %0d distinct latencies expected >= 2", $countones(seen));
      end
      idle(3);
   endtask
`else
   task automatic test_read_w2;
      int ac, an, sf, sc;
      logic [31:0] rd;
      run_req(2, 1'b0, 30'h0010_0000, 4'hF, 32'h0, -1, 10, ac, an, sf, sc, rd);
      n_checks++;
      if (sf != 3 || sc != 1) begin n_fail++; $display("FAIL read_stb: first %0d count %0d expected 3/1", sf, sc); end
      n_checks++;
      if (ac != 4 || an != 1) begin n_fail++; $display("FAIL read_ack: cycle %0d count %0d expected 4/1", ac, an); end
      n_checks++;
      if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL read_data: got %h expected 12345678", rd); end
      idle(2);
   endtask

   task automatic test_write_w0;
      int ac, an, sf, sc;
      logic [31:0] rd;
      run_req(0, 1'b1, 30'h0020_0005, 4'b0011, 32'hAABB_CCDD, -1, 6, ac, an, sf, sc, rd);
      n_checks++;
      if (ac != 2 || sf != 1 || sc != 1) begin
         n_fail++; $display("FAIL write_timing: ack %0d stb %0d/%0d expected 2, 1/1", ac, sf, sc);
      end
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL write_hold_mdat: got %h expected 00000000", rd); end
      idle(2);
      run_req(0, 1'b0, 30'h0020_0005, 4'hF, 32'h0, -1, 6, ac, an, sf, sc, rd);
      n_checks++;
      if (ac != 2 || rd !== 32'h1122_CCDD) begin
         n_fail++; $display("FAIL write_readback: ack %0d data %h expected 2, 1122ccdd", ac, rd);
      end
      idle(2);
   endtask

   task automatic test_back_to_back;
      int a1, a2, n_ack;
      logic [31:0] d1, d2;
      a1 = -1; a2 = -1; n_ack = 0; d1 = '0; d2 = '0;
      act = 0; m_we = 1'b0; m_sel = 4'hF; m_adr = 30'h0010_0000;
      m_cyc = 1'b1; m_stb = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus_w0.m_ack_o) begin
            if (n_ack == 0) begin a1 = c; d1 = bus_w0.m_dat_o; end
            if (n_ack == 1) begin a2 = c; d2 = bus_w0.m_dat_o; end
            n_ack++;
         end
         @(posedge clk); #1;
         if (n_ack == 1 && a1 == c) m_adr = 30'h0010_0001;
         if (n_ack == 2 && a2 == c) begin m_cyc = 1'b0; m_stb = 1'b0; end
      end
      m_cyc = 1'b0; m_stb = 1'b0;
      n_checks++;
      if (a1 != 2 || a2 != 5 || n_ack != 2) begin
         n_fail++; $display("FAIL b2b_acks: %0d,%0d count %0d expected 2,5 count 2", a1, a2, n_ack);
      end
      n_checks++;
      if (d1 !== 32'h1234_5678 || d2 !== 32'hCAFE_F00D) begin
         n_fail++; $display("FAIL b2b_data: got %h,%h expected 12345678,cafef00d", d1, d2);
      end
      idle(2);
   endtask

   task automatic test_abort;
      int ac, an, sf, sc;
      logic [31:0] rd;
      run_req(3, 1'b0, 30'h0010_0001, 4'hF, 32'h0, 2, 10, ac, an, sf, sc, rd);
      n_checks++;
      if (sc != 0 || an != 0) begin n_fail++; $display("FAIL abort_wait: stb %0d ack %0d expected 0/0", sc, an); end
      run_req(3, 1'b0, 30'h0010_0001, 4'hF, 32'h0, -1, 8, ac, an, sf, sc, rd);
      n_checks++;
      if (ac != 5 || rd !== 32'hCAFE_F00D) begin
         n_fail++; $display("FAIL abort_recover: ack %0d data %h expected 5, cafef00d", ac, rd);
      end
      idle(2);
   endtask

   task automatic test_access_drop;
      int ac, an, sf, sc;
      logic [31:0] rd;
      run_req(2, 1'b0, 30'h0010_0000, 4'hF, 32'h0, 3, 8, ac, an, sf, sc, rd);
      n_checks++;
      if (sf != 3 || sc != 1 || an != 0) begin
         n_fail++; $display("FAIL access_drop: stb %0d/%0d ack %0d expected 3/1, 0", sf, sc, an);
      end
      idle(2);
   endtask

   task automatic test_timeout;
      int ac, an, sf, sc;
      logic [31:0] rd;
      run_req(2, 1'b0, 30'h0, 4'hF, 32'h0, -1, 24, ac, an, sf, sc, rd);
      n_checks++;
      if (ac != 20 || an != 1 || sc != 17) begin
         n_fail++; $display("FAIL timeout_timing: ack %0d count %0d stb %0d expected 20,1,17", ac, an, sc);
      end
      n_checks++;
      if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL timeout_data: got %h expected deadbeef", rd); end
      idle(10);
      n_checks++;
      if (bus_w2.fault_o !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got %b expected 1", bus_w2.fault_o); end
      run_req(2, 1'b0, 30'h0010_0001, 4'hF, 32'h0, -1, 8, ac, an, sf, sc, rd);
      n_checks++;
      if (ac != 4 || rd !== 32'hCAFE_F00D || bus_w2.fault_o !== 1'b1) begin
         n_fail++; $display("FAIL fault_after_read: ack %0d data %h fault %b expected 4, cafef00d, 1", ac, rd, bus_w2.fault_o);
      end
      @(negedge clk); rst = 1'b1;
      #1;
      n_checks++;
      if (bus_w2.fault_o !== 1'b0) begin n_fail++; $display("FAIL fault_reset: got %b expected 0", bus_w2.fault_o); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_reset_mid;
      logic found;
      int   late_stb, late_ack;
      found = 1'b0; late_stb = 0; late_ack = 0;
      act = 2; m_we = 1'b0; m_sel = 4'hF; m_adr = 30'h0010_0001;
      m_cyc = 1'b1; m_stb = 1'b1;
      for (int c = 0; c < 24 && !found; c++) begin
         @(negedge clk);
         if (bus_w2.s_stb_o) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_fail++; $display("FAIL reset_mid_reach: s_stb_o not seen within 24 cycles, expected 1");
      end
      rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
      #1;
      n_checks++;
      if ({bus_w2.s_cyc_o, bus_w2.s_stb_o, bus_w2.m_ack_o, bus_w2.s_we_o} !== 4'b0 ||
          bus_w2.s_adr_o !== 30'h0 || bus_w2.m_dat_o !== 32'h0 || bus_w2.s_sel_o !== 4'h0) begin
         n_fail++; $display("FAIL reset_mid_outputs: ctrl %b adr %h mdat %h sel %h expected all 0",
            {bus_w2.s_cyc_o, bus_w2.s_stb_o, bus_w2.m_ack_o, bus_w2.s_we_o},
            bus_w2.s_adr_o, bus_w2.m_dat_o, bus_w2.s_sel_o);
      end
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus_w2.s_stb_o) late_stb++;
         if (bus_w2.m_ack_o) late_ack++;
      end
      n_checks++;
      if (late_stb != 0 || late_ack != 0) begin
         n_fail++; $display("FAIL reset_mid_quiet: stb %0d ack %0d expected 0/0", late_stb, late_ack);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #2;
      test_reset;
`ifdef WB_RANDOM_WAIT_EN
      test_random;
`else
      test_read_w2;
      test_write_w0;
      test_back_to_back;
      test_abort;
      test_access_drop;
      test_timeout;
`endif
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
